chu_pad_param: RTL and testbench

Parametrised message padding engine for the hash datapath: accepts a message as a stream of words framed by `sop`/`eop`, appends the Merkle–Damgård padding (0x80 marker, zero fill, message bit-length), and delivers complete `BLOCK_WORDS`-word blocks to the compression core with a valid/ready handshake. It is the successor to the fixed 16×32-bit padder, adding generic word, block and length widths, partial final words, output backpressure, multi-block messages and protocol-error reporting. Defaults (32/16/64) give SHA-256 (`alg=0`) and MD5 (`alg=1`) blocks.

---
 rtl/chu_pad_param.sv | 238 +++++++++++++++++++++++
 tb/tb_chu_pad_param.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chu_pad_param.sv
`default_nettype none
// ============================================================================
// Module   : chu_pad_param
// Brief    : Merkle-Damgard padding engine; frames words into padded blocks.
// Revision : 1.0 - initial release
// ============================================================================
module chu_pad_param #(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 16,
    parameter int LEN_W       = 64,
    parameter int CNT_W       = 16,
    localparam int NB_W       = (WORD_W / 8 > 1) ? $clog2(WORD_W / 8) : 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_reset,
    input  logic                          val,
    input  logic                          sop,
    input  logic                          eop,
    input  logic [WORD_W-1:0]             data,
    input  logic [NB_W-1:0]               nbytes,
    input  logic                          alg,
    output logic                          in_rdy,
    output logic [WORD_W*BLOCK_WORDS-1:0] blk,
    output logic                          blk_val,
    output logic                          blk_last,
    input  logic                          blk_rdy,
    output logic [CNT_W-1:0]              mes_cnt,
    output logic                          err
);

    localparam int c_nbytes = WORD_W / 8;
    localparam int c_lw     = LEN_W / WORD_W;
    localparam int c_widx_w = $clog2(BLOCK_WORDS + 1);
    localparam logic [c_widx_w-1:0] c_widx_one = c_widx_w'(1);

    if ((WORD_W % 8) != 0 || WORD_W < 8) begin : g_bad_word_w
        $error("chu_pad_param: WORD_W must be a multiple of 8 and at least 8");
    end
    if ((LEN_W % WORD_W) != 0 || c_lw > BLOCK_WORDS - 1) begin : g_bad_len_w
        $error("chu_pad_param: LEN_W must be a multiple of WORD_W and fit in a block");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_MARK = 3'd2,
        S_LEN  = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                r_after;
    logic [WORD_W-1:0]     r_buf [BLOCK_WORDS];
    logic [c_widx_w-1:0]   r_widx;
    logic [LEN_W-1:0]      r_len;
    logic                  r_alg;
    logic                  r_last;
    logic [CNT_W-1:0]      r_mes_cnt;
    logic                  r_err;

    state_t                w_state_nx;
    state_t                w_after_nx;
    logic [WORD_W-1:0]     w_buf_nx [BLOCK_WORDS];
    logic [c_widx_w-1:0]   w_widx_nx;
    logic [LEN_W-1:0]      w_len_nx;
    logic                  w_alg_nx;
    logic                  w_last_nx;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic                  w_err_nx;
    logic [c_widx_w-1:0]   w_idx;
    logic [WORD_W-1:0]     w_word;
    logic                  w_partial;
    logic                  w_pad_here;

    // Keeps the first n bytes, puts the 0x80 marker in byte n and zeroes the rest.
    // With n = 0 this yields the stand-alone marker word.
    function automatic logic [WORD_W-1:0] f_pad_word(input logic [WORD_W-1:0] d,
                                                     input int n,
                                                     input logic le);
        logic [WORD_W-1:0] w;
        int                p;
        w = '0;
        for (int k = 0; k < c_nbytes; k++) begin
            p = le ? 8 * k : 8 * (c_nbytes - 1 - k);
            if (k < n) begin
                w[p +: 8] = d[p +: 8];
            end else if (k == n) begin
                w[p +: 8] = 8'h80;
            end
        end
        return w;
    endfunction

    // Word j of the length trailer: most significant word first for big-endian.
    function automatic logic [WORD_W-1:0] f_len_word(input logic [LEN_W-1:0] len,
                                                     input int j,
                                                     input logic le);
        return le ? len[j * WORD_W +: WORD_W] : len[(c_lw - 1 - j) * WORD_W +: WORD_W];
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_after_nx = r_after;
        w_buf_nx   = r_buf;
        w_widx_nx  = r_widx;
        w_len_nx   = r_len;
        w_alg_nx   = r_alg;
        w_last_nx  = r_last;
        w_cnt_nx   = r_mes_cnt;
        w_err_nx   = 1'b0;
        w_idx      = r_widx;
        w_word     = data;
        w_partial  = (nbytes != '0) && (int'(nbytes) < c_nbytes);
        w_pad_here = eop && w_partial;

        case (r_state)
            S_IDLE, S_FILL: begin
                if (val) begin
                    if (r_state == S_IDLE && !sop) begin
                        w_err_nx = 1'b1;
                    end else begin
                        // A sop always opens a fresh message; inside FILL it aborts the old one.
                        if (sop) begin
                            if (r_state == S_FILL) begin
                                w_err_nx = 1'b1;
                            end
                            for (int i = 0; i < BLOCK_WORDS; i++) begin
                                w_buf_nx[i] = '0;
                            end
                            w_idx    = '0;
                            w_len_nx = '0;
                            w_alg_nx = alg;
                        end
                        w_word   = w_pad_here ? f_pad_word(data, int'(nbytes), w_alg_nx) : data;
                        w_len_nx = w_len_nx + (w_pad_here ? (LEN_W'(nbytes) << 3) : LEN_W'(WORD_W));
                        for (int i = 0; i < BLOCK_WORDS; i++) begin
                            if (i == int'(w_idx)) begin
                                w_buf_nx[i] = w_word;
                            end
                        end
                        w_widx_nx = w_idx + c_widx_one;
                        if (w_pad_here) begin
                            w_state_nx = S_LEN;
                        end else if (int'(w_idx) == BLOCK_WORDS - 1) begin
                            w_state_nx = S_EMIT;
                            w_last_nx  = 1'b0;
                            w_after_nx = eop ? S_MARK : S_FILL;
                        end else begin
                            w_state_nx = eop ? S_MARK : S_FILL;
                        end
                    end
                end
            end

            S_MARK: begin
                for (int i = 0; i < BLOCK_WORDS; i++) begin
                    if (i == int'(r_widx)) begin
                        w_buf_nx[i] = f_pad_word('0, 0, r_alg);
                    end
                end
                w_widx_nx  = r_widx + c_widx_one;
                w_state_nx = S_LEN;
            end

            S_LEN: begin
                w_state_nx = S_EMIT;
                if (int'(r_widx) <= BLOCK_WORDS - c_lw) begin
                    for (int j = 0; j < c_lw; j++) begin
                        w_buf_nx[BLOCK_WORDS - c_lw + j] = f_len_word(r_len, j, r_alg);
                    end
                    w_last_nx = 1'b1;
                end else begin
                    // No room for the trailer: ship this block and put it in an all-zero one.
                    w_last_nx  = 1'b0;
                    w_after_nx = S_LEN;
                end
            end

            S_EMIT: begin
                if (blk_rdy) begin
                    for (int i = 0; i < BLOCK_WORDS; i++) begin
                        w_buf_nx[i] = '0;
                    end
                    w_widx_nx = '0;
                    if (r_last) begin
                        w_cnt_nx   = r_mes_cnt + CNT_W'(1);
                        w_last_nx  = 1'b0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = r_after;
                    end
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state   <= S_IDLE;
            r_after   <= S_IDLE;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_buf[i] <= '0;
            end
            r_widx    <= '0;
            r_len     <= '0;
            r_alg     <= 1'b0;
            r_last    <= 1'b0;
            r_mes_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_after   <= w_after_nx;
            r_buf     <= w_buf_nx;
            r_widx    <= w_widx_nx;
            r_len     <= w_len_nx;
            r_alg     <= w_alg_nx;
            r_last    <= w_last_nx;
            r_mes_cnt <= w_cnt_nx;
            r_err     <= w_err_nx;
        end
    end

    for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_blk
        assign blk[gi * WORD_W +: WORD_W] = r_buf[gi];
    end

    assign in_rdy   = (r_state == S_IDLE) || (r_state == S_FILL);
    assign blk_val  = (r_state == S_EMIT);
    assign blk_last = r_last;
    assign mes_cnt  = r_mes_cnt;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_chu_pad_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_chu_pad_param
// Brief    : Randomised self-checking bench for chu_pad_param (32/16/64 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chu_pad_param;

    localparam int WW  = 32;
    localparam int BW  = 16;
    localparam int NBY = WW / 8;
    localparam int BBY = BW * NBY;
    localparam int LBY = 8;

    typedef byte unsigned bq_t[$];
    typedef logic [WW*BW-1:0] blk_t;

    logic          sys_clk   = 1'b0;
    logic          sys_reset = 1'b0;
    logic          val       = 1'b0;
    logic          sop       = 1'b0;
    logic          eop       = 1'b0;
    logic [WW-1:0] data      = '0;
    logic [1:0]    nbytes    = '0;
    logic          alg       = 1'b0;
    logic          blk_rdy   = 1'b0;
    logic          in_rdy;
    blk_t          blk;
    logic          blk_val;
    logic          blk_last;
    logic [15:0]   mes_cnt;
    logic          err;

    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_cnt = 0;
    blk_t exp_blk[$];
    bit   exp_last[$];
    blk_t got_blk[$];
    bit   got_last[$];

    chu_pad_param #(
        .WORD_W     (WW),
        .BLOCK_WORDS(BW),
        .LEN_W      (64),
        .CNT_W      (16)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .val      (val),
        .sop      (sop),
        .eop      (eop),
        .data     (data),
        .nbytes   (nbytes),
        .alg      (alg),
        .in_rdy   (in_rdy),
        .blk      (blk),
        .blk_val  (blk_val),
        .blk_last (blk_last),
        .blk_rdy  (blk_rdy),
        .mes_cnt  (mes_cnt),
        .err      (err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Textbook MD padding on a byte stream, then packed into words by byte order.
    function automatic void build_exp(input bq_t m, input bit a);
        bq_t         p;
        logic [63:0] bits;
        blk_t        bv;
        logic [WW-1:0] wd;
        byte unsigned by;
        int          nb;
        p = m;
        p.push_back(8'h80);
        while ((p.size() % BBY) != BBY - LBY) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int k = 0; k < LBY; k++)
            p.push_back(a ? bits[8*k +: 8] : bits[8*(LBY-1-k) +: 8]);
        nb = p.size() / BBY;
        for (int b = 0; b < nb; b++) begin
            bv = '0;
            for (int w = 0; w < BW; w++) begin
                wd = '0;
                for (int k = 0; k < NBY; k++) begin
                    by = p[b*BBY + w*NBY + k];
                    if (a) wd[8*k +: 8] = by;
                    else   wd[8*(NBY-1-k) +: 8] = by;
                end
                bv[w*WW +: WW] = wd;
            end
            exp_blk.push_back(bv);
            exp_last.push_back(b == nb - 1);
        end
    endfunction

    // Bytes past the end of the message are random filler the padder must overwrite.
    function automatic logic [WW-1:0] mkword(input bq_t m, input int wi, input bit a);
        logic [WW-1:0] w;
        byte unsigned  by;
        int            idx;
        w = '0;
        for (int k = 0; k < NBY; k++) begin
            idx = wi * NBY + k;
            by  = (idx < m.size()) ? m[idx] : 8'($urandom);
            if (a) w[8*k +: 8] = by;
            else   w[8*(NBY-1-k) +: 8] = by;
        end
        return w;
    endfunction

    task automatic run_msg(input bq_t m, input bit a, input int val_pct, input int rdy_pct,
                           input int hold, input bit exp_err, output int lat);
        int   nw, wi, iter, eop_it, first_acc, nblk, held;
        bit   err_bad, inrdy_bad, stab_bad, prev_pend, prev_last, exp_e;
        blk_t prev_blk;
        exp_blk.delete(); exp_last.delete(); got_blk.delete(); got_last.delete();
        build_exp(m, a);
        nw = (m.size() + NBY - 1) / NBY;
        wi = 0; iter = 0; eop_it = -1; first_acc = -1; nblk = 0; held = 0; lat = -1;
        err_bad = 0; inrdy_bad = 0; stab_bad = 0; prev_pend = 0; prev_last = 0; prev_blk = '0;
        @(negedge sys_clk);
        while (nblk < exp_blk.size() && iter < 4000) begin
            if (wi < nw && $urandom_range(99) < val_pct) begin
                val    = 1'b1;
                sop    = (wi == 0);
                eop    = (wi == nw - 1);
                alg    = (wi == 0) ? a : 1'($urandom);
                data   = mkword(m, wi, a);
                nbytes = eop ? 2'(m.size() % NBY) : 2'($urandom);
            end else begin
                val    = 1'b0;
                sop    = 1'($urandom);
                eop    = 1'($urandom);
                alg    = 1'($urandom);
                data   = $urandom;
                nbytes = 2'($urandom);
            end
            if (blk_val && held < hold) begin
                blk_rdy = 1'b0;
                held++;
            end else begin
                blk_rdy = ($urandom_range(99) < rdy_pct);
            end
            exp_e = exp_err && (first_acc >= 0) && (iter == first_acc + 1);
            if (err !== exp_e) err_bad = 1;
            if (blk_val && in_rdy) inrdy_bad = 1;
            if (prev_pend && (!blk_val || blk !== prev_blk || blk_last !== prev_last)) stab_bad = 1;
            if (blk_val && eop_it >= 0 && lat < 0) lat = iter - eop_it;
            if (val && in_rdy) begin
                if (wi == 0) first_acc = iter;
                if (eop) eop_it = iter;
                wi++;
            end
            prev_pend = 0;
            if (blk_val) begin
                if (blk_rdy) begin
                    n_cmp++;
                    if (blk !== exp_blk[nblk] || blk_last !== exp_last[nblk]) begin
                        n_bad++;
                        $display("FAIL block%0d: got last=%0b %h want last=%0b %h",
                                 nblk, blk_last, blk, exp_last[nblk], exp_blk[nblk]);
                    end
                    got_blk.push_back(blk);
                    got_last.push_back(blk_last);
                    nblk++;
                    held = 0;
                end else begin
                    prev_pend = 1;
                    prev_blk  = blk;
                    prev_last = blk_last;
                end
            end
            @(posedge sys_clk);
            @(negedge sys_clk);
            iter++;
        end
        val = 1'b0; sop = 1'b0; eop = 1'b0; blk_rdy = 1'b0;
        exp_cnt++;
        n_cmp++;
        if (nblk != exp_blk.size()) begin
            n_bad++;
            $display("FAIL msg_timeout: got %0d blocks want %0d", nblk, exp_blk.size());
        end
        n_cmp++;
        if (err_bad) begin n_bad++; $display("FAIL err_pulse: unexpected err behaviour, want pulse=%0b", exp_err); end
        n_cmp++;
        if (inrdy_bad || stab_bad) begin
            n_bad++;
            $display("FAIL emit_hold: in_rdy_during_emit=%0b unstable=%0b want 0/0", inrdy_bad, stab_bad);
        end
        n_cmp++;
        if (in_rdy !== 1'b1 || blk_val !== 1'b0) begin
            n_bad++;
            $display("FAIL post_emit: in_rdy=%b blk_val=%b want 1/0", in_rdy, blk_val);
        end
        n_cmp++;
        if (mes_cnt !== 16'(exp_cnt)) begin
            n_bad++;
            $display("FAIL mes_cnt: got %0d want %0d", mes_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        sys_reset = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_cmp++; if (in_rdy !== 1'b1)   begin n_bad++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        n_cmp++; if (blk_val !== 1'b0)  begin n_bad++; $display("FAIL reset_blk_val: got %b want 0", blk_val); end
        n_cmp++; if (blk_last !== 1'b0) begin n_bad++; $display("FAIL reset_blk_last: got %b want 0", blk_last); end
        n_cmp++; if (mes_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_mes_cnt: got %0d want 0", mes_cnt); end
        n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (blk !== '0)        begin n_bad++; $display("FAIL reset_blk: got %h want 0", blk); end
        sys_reset = 1'b1;
        exp_cnt = 0;
        @(negedge sys_clk);
    endtask

    task automatic test_abc_sha();
        bq_t  m;
        blk_t e, g;
        int   lat;
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0, 100, 100, 0, 1'b0, lat);
        e = '0;
        e[0*32 +: 32]  = 32'h61626380;
        e[15*32 +: 32] = 32'h00000018;
        g = (got_blk.size() > 0) ? got_blk[0] : '0;
        n_cmp++; if (got_blk.size() != 1) begin n_bad++; $display("FAIL abc_sha_count: got %0d want 1", got_blk.size()); end
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL abc_sha_block: got %h want %h", g, e); end
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL abc_sha_latency: got %0d want 2", lat); end
    endtask

    task automatic test_abc_md5();
        bq_t  m;
        blk_t e, g;
        int   lat;
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b1, 100, 100, 0, 1'b0, lat);
        e = '0;
        e[0*32 +: 32]  = 32'h80636261;
        e[14*32 +: 32] = 32'h00000018;
        g = (got_blk.size() > 0) ? got_blk[0] : '0;
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL abc_md5_block: got %h want %h", g, e); end
        n_cmp++; if (got_last.size() == 0 || got_last[0] !== 1'b1) begin n_bad++; $display("FAIL abc_md5_last: want last=1 in single block"); end
    endtask

    task automatic test_56();
        bq_t  m;
        blk_t e, g0, g1;
        int   lat;
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0, 100, 100, 0, 1'b0, lat);
        e = '0;
        e[15*32 +: 32] = 32'h000001C0;
        g0 = (got_blk.size() > 0) ? got_blk[0] : '0;
        g1 = (got_blk.size() > 1) ? got_blk[1] : '0;
        n_cmp++; if (g0[14*32 +: 32] !== 32'h80000000 || g0[15*32 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL b56_block1_tail: got %h_%h want 00000000_80000000", g0[15*32 +: 32], g0[14*32 +: 32]); end
        n_cmp++; if (g1 !== e) begin n_bad++; $display("FAIL b56_block2: got %h want %h", g1, e); end
        n_cmp++; if (got_last.size() != 2 || got_last[0] !== 1'b0) begin n_bad++; $display("FAIL b56_last: want two blocks, first non-final"); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL b56_latency: got %0d want 3", lat); end
    endtask

    task automatic test_64();
        bq_t  m;
        blk_t e, g1;
        int   lat;
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0, 100, 100, 0, 1'b0, lat);
        e = '0;
        e[0*32 +: 32]  = 32'h80000000;
        e[15*32 +: 32] = 32'h00000200;
        g1 = (got_blk.size() > 1) ? got_blk[1] : '0;
        n_cmp++; if (g1 !== e) begin n_bad++; $display("FAIL b64_block2: got %h want %h", g1, e); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL b64_latency: got %0d want 1", lat); end
    endtask

    task automatic test_backpressure();
        bq_t m;
        int  lat;
        for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0, 100, 100, 5, 1'b0, lat);
        for (int i = 0; i < 130; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b1, 100, 100, 5, 1'b0, lat);
    endtask

    task automatic test_err_nosop();
        bit saw_blk;
        @(negedge sys_clk);
        val = 1'b1; sop = 1'b0; eop = 1'b1; data = $urandom; nbytes = 2'd0;
        @(negedge sys_clk);
        val = 1'b0; eop = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL nosop_err: got %b want 1", err); end
        @(negedge sys_clk);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL nosop_err_width: got %b want 0", err); end
        saw_blk = 0;
        repeat (5) begin
            if (blk_val) saw_blk = 1;
            @(negedge sys_clk);
        end
        n_cmp++; if (saw_blk || mes_cnt !== 16'(exp_cnt)) begin
            n_bad++; $display("FAIL nosop_quiet: blk_seen=%0b mes_cnt=%0d want 0/%0d", saw_blk, mes_cnt, exp_cnt); end
    endtask

    task automatic test_err_restart();
        bq_t m;
        int  lat;
        for (int i = 0; i < 3; i++) begin
            val = 1'b1; sop = (i == 0); eop = 1'b0; alg = 1'($urandom); data = $urandom;
            @(negedge sys_clk);
        end
        val = 1'b0; sop = 1'b0;
        for (int i = 0; i < $urandom_range(5, 40); i++) m.push_back(8'($urandom));
        run_msg(m, 1'($urandom), 100, 70, 0, 1'b1, lat);
    endtask

    task automatic test_reset_mid();
        bq_t m;
        int  lat, waited;
        for (int i = 0; i < BW; i++) begin
            val = 1'b1; sop = (i == 0); eop = 1'b0; alg = 1'b0; data = $urandom;
            @(negedge sys_clk);
        end
        val = 1'b0; sop = 1'b0; blk_rdy = 1'b0;
        waited = 0;
        while (!blk_val && waited < 10) begin
            @(negedge sys_clk);
            waited++;
        end
        n_cmp++; if (blk_val !== 1'b1) begin n_bad++; $display("FAIL pre_reset_emit: blk_val=%b want 1", blk_val); end
        sys_reset = 1'b0;
        #1;
        n_cmp++; if (blk_val !== 1'b0 || blk_last !== 1'b0 || blk !== '0) begin
            n_bad++; $display("FAIL midreset_blk: blk_val=%b blk_last=%b blk_nonzero=%b want 0/0/0", blk_val, blk_last, |blk); end
        n_cmp++; if (in_rdy !== 1'b1 || mes_cnt !== 16'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL midreset_ctl: in_rdy=%b mes_cnt=%0d err=%b want 1/0/0", in_rdy, mes_cnt, err); end
        @(negedge sys_clk);
        sys_reset = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) m.push_back(8'($urandom));
        run_msg(m, 1'b0, 100, 100, 0, 1'b0, lat);
    endtask

    task automatic test_random();
        bq_t m;
        int  lat, len;
        for (int t = 0; t < 20; t++) begin
            m.delete();
            len = $urandom_range(1, 200);
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            run_msg(m, 1'($urandom), $urandom_range(50, 100), $urandom_range(30, 100), 0, 1'b0, lat);
        end
    endtask

    initial begin
        test_reset();
        test_abc_sha();
        test_abc_md5();
        test_56();
        test_64();
        test_backpressure();
        test_err_nosop();
        test_err_restart();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
